raybox_input_ctrl: RTL and testbench
====================================

Name: raybox_input_ctrl

Overview:
- Input sequencer between the four external direction buttons (K4..K1) and the raybox core's move/debug inputs.
- Per-button pipeline: synchronise, then debounce.
- A chord state machine decides whether the buttons are issuing movement or one of the two debug modes.
- Commands are latched once per frame, on `frame_tick`, so the renderer sees inputs that are stable for a whole frame.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a debounced button changes (10 ms at 25 MHz); minimum 2.
- CHORD_WINDOW, 1250000, cycles a single press waits for a chord partner before committing to movement (50 ms); minimum 1.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- btn_n  in  4  raw buttons, active-low, unsynchronised; bit3=K4 (forward), bit2=K3 (left), bit1=K2 (right), bit0=K1 (back).
- frame_tick  in  1  one-cycle strobe at frame start; command outputs update only on it.
- moveF, moveB, moveL, moveR  out  1 each  registered movement commands.
- debugA, debugB, debugC, debugD  out  1 each  registered debug commands.
- mode  out  3  current FSM state encoding, live (for LEDs): IDLE=0, PEND=1, MOVE=2, DBG1=3, DBG2=4, REL=5.

Behaviour:
- Reset (async, active-high):
  - sync flops go to "not pressed" (1); debounced vector p=0.
  - all counters 0; state IDLE.
  - every move/debug output 0; mode=0.
  - Reset asserted mid-operation aborts any press, window or debug mode in the same instant.
- Synchroniser: two flops per bit; pressed sample s[i] = ~sync2[i].
- Debounce, per bit:
  - if s[i]==p[i], the counter clears;
  - else the counter increments, and when it reaches DEBOUNCE_CYCLES-1 with s[i] still differing, p[i] takes s[i] and the counter clears.
  - A raw change held stable appears on p on rising edge DEBOUNCE_CYCLES+2 after the edge where it is first sampled.
  - Glitches shorter than DEBOUNCE_CYCLES never reach p.
- Chord definitions: C1 = p[2]&p[1] (K3+K2); C2 = p[3]&p[0] (K4+K1). If both are true, C1 wins.
- FSM (transitions every clk, from p):
  - IDLE: p==0 stays. C1 goes to DBG1; C2 goes to DBG2. Any other nonzero p goes to PEND and loads the window counter with CHORD_WINDOW-1.
  - PEND:
    - C1 goes to DBG1; C2 goes to DBG2.
    - p==0 goes to IDLE. A tap shorter than the window produces no command.
    - Counter==0 goes to MOVE; otherwise the counter decrements.
  - MOVE:
    - Command is F=p[3], B=p[0], L=p[2], R=p[1].
    - Opposing pairs cancel: if F and B are both set, both become 0; same for L and R.
    - Chords are not recognised in MOVE. p==0 goes to IDLE.
  - DBG1: command is debugA=p[3], debugB=p[0]. If p[2] or p[1] is released, go to REL.
  - DBG2: command is debugC=p[1], debugD=p[2]. If p[3] or p[0] is released, go to REL.
  - REL: command is all 0; p==0 goes to IDLE. This prevents a residual button from being misread as movement.
  - In IDLE and PEND the command is all 0.
- Output latch:
  - On a clk edge with frame_tick=1, all eight outputs load the command computed from the current state and p.
  - With frame_tick=0 the outputs hold.
  - Latency from a state/p change to the outputs is ≤1 frame.
  - A frame_tick in the same cycle as a state transition latches the pre-transition command.

Optional Feature:
- RAYBOX_INPUT_DEBUG_PULSE_EN:
  - When defined, each debug output asserts for exactly one frame per press.
  - A per-output armed flag sets when the command bit is 0 at a frame_tick. The output is 1 only on the first frame_tick where the command bit is 1 and the flag is armed; this clears the flag.
  - Flags reset to armed.
- When undefined: debug outputs are levels, exactly as the command.
- Move outputs are levels in both cases.

Test Plan (DEBOUNCE_CYCLES=4, CHORD_WINDOW=8, frame_tick every 32 clk):
- Reset: assert reset mid-cycle -> all outputs 0 and mode=0 immediately, with no clk edge. Release, all btn_n=1, 200 clk -> outputs stay 0, mode=0.
- Bounce: btn_n[3] low for 3 clk, high for 2, low for 3, then high -> p never changes; mode stays 0; no output pulse.
- Move: hold btn_n[3]=0 -> mode=1 at edge 7, mode=2 eight cycles later; moveF=1 at the next frame_tick. Release -> moveF=0 at the first frame_tick after mode returns to 0.
- Chord: press K3 and K2 within 4 clk -> mode goes to 3, never 2. Add K4 -> debugA=1 at the next frame_tick. Release K2 -> mode=5, then 0 after all are released; debugA=0.
- Opposing and priority:
  - In MOVE with K3 held, add K2 -> moveL=moveR=0 and mode stays 2.
  - All four pressed together from IDLE -> mode=3.
- Pulse (macro defined): DBG2 with K2 held 5 frames -> debugC=1 for exactly one frame. Release and re-press K2 -> exactly one more pulse.

Source files
------------

// File: rtl/raybox_input_ctrl_if.sv
// Button/command bundle between the board buttons, the frame timer and the raybox core.
// The controller uses the slave side; whatever drives the buttons and frame strobe uses master.
interface raybox_input_ctrl_if;
    logic [3:0] btn_n;
    logic       frame_tick;
    logic       moveF;
    logic       moveB;
    logic       moveL;
    logic       moveR;
    logic       debugA;
    logic       debugB;
    logic       debugC;
    logic       debugD;
    logic [2:0] mode;

    modport master (
        output btn_n, frame_tick,
        input  moveF, moveB, moveL, moveR, debugA, debugB, debugC, debugD, mode
    );

    modport slave (
        input  btn_n, frame_tick,
        output moveF, moveB, moveL, moveR, debugA, debugB, debugC, debugD, mode
    );
endinterface

// File: rtl/raybox_input_ctrl.sv
// Button sequencer for raybox: synchronise, debounce, chord FSM, per-frame command latch.
// Define RAYBOX_INPUT_DEBUG_PULSE_EN to make each debug output a one-frame pulse per press.
module raybox_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CHORD_WINDOW    = 1250000
) (
    input  logic                 clk,
    input  logic                 reset,
    raybox_input_ctrl_if.slave   bus
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int WIN_W = $clog2(CHORD_WINDOW + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(CHORD_WINDOW - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PEND = 3'd1;
    localparam logic [2:0] ST_MOVE = 3'd2;
    localparam logic [2:0] ST_DBG1 = 3'd3;
    localparam logic [2:0] ST_DBG2 = 3'd4;
    localparam logic [2:0] ST_REL  = 3'd5;

    logic [3:0]            sync1_q, sync1_d;
    logic [3:0]            sync2_q, sync2_d;
    logic [3:0]            p_q, p_d;
    logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0]            state_q, state_d;
    logic [WIN_W-1:0]      win_q, win_d;
    logic [3:0]            move_q, move_d;
    logic [3:0]            dbg_q, dbg_d;
    logic [3:0]            s;
    logic                  c1, c2;
    logic [3:0]            cmd_move;
    logic [3:0]            cmd_dbg;

    always_comb begin
        sync1_d = bus.btn_n;
        sync2_d = sync1_q;
        s       = ~sync2_q;
        p_d     = p_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (s[i] != p_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    p_d[i] = s[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Chord K3+K2 outranks K4+K1 when all four are down.
    always_comb begin
        c1      = p_q[2] & p_q[1];
        c2      = p_q[3] & p_q[0];
        state_d = state_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                if (c1)              state_d = ST_DBG1;
                else if (c2)         state_d = ST_DBG2;
                else if (p_q != '0) begin
                    state_d = ST_PEND;
                    win_d   = WIN_LOAD;
                end
            end
            ST_PEND: begin
                if (c1)              state_d = ST_DBG1;
                else if (c2)         state_d = ST_DBG2;
                else if (p_q == '0)  state_d = ST_IDLE;
                else if (win_q == '0) state_d = ST_MOVE;
                else                 win_d = win_q - WIN_W'(1);
            end
            ST_MOVE: if (p_q == '0)           state_d = ST_IDLE;
            ST_DBG1: if (!p_q[2] || !p_q[1])  state_d = ST_REL;
            ST_DBG2: if (!p_q[3] || !p_q[0])  state_d = ST_REL;
            ST_REL:  if (p_q == '0)           state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // Command vectors: move = {F,B,L,R}, debug = {A,B,C,D}; opposing moves cancel.
    always_comb begin
        cmd_move = '0;
        cmd_dbg  = '0;
        case (state_q)
            ST_MOVE: cmd_move = {p_q[3] & ~p_q[0], p_q[0] & ~p_q[3],
                                 p_q[2] & ~p_q[1], p_q[1] & ~p_q[2]};
            ST_DBG1: cmd_dbg  = {p_q[3], p_q[0], 2'b00};
            ST_DBG2: cmd_dbg  = {2'b00, p_q[1], p_q[2]};
            default: ;
        endcase
    end

`ifdef RAYBOX_INPUT_DEBUG_PULSE_EN
    logic [3:0] armed_q, armed_d;

    // A bit re-arms on any frame where its command is low, so holding yields one pulse.
    always_comb begin
        move_d  = move_q;
        dbg_d   = dbg_q;
        armed_d = armed_q;
        if (bus.frame_tick) begin
            move_d  = cmd_move;
            dbg_d   = cmd_dbg & armed_q;
            armed_d = ~cmd_dbg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) armed_q <= 4'hF;
        else       armed_q <= armed_d;
    end
`else
    always_comb begin
        move_d = move_q;
        dbg_d  = dbg_q;
        if (bus.frame_tick) begin
            move_d = cmd_move;
            dbg_d  = cmd_dbg;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 4'hF;
            sync2_q  <= 4'hF;
            p_q      <= '0;
            db_cnt_q <= '0;
            state_q  <= ST_IDLE;
            win_q    <= '0;
            move_q   <= '0;
            dbg_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            p_q      <= p_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            win_q    <= win_d;
            move_q   <= move_d;
            dbg_q    <= dbg_d;
        end
    end

    assign bus.moveF  = move_q[3];
    assign bus.moveB  = move_q[2];
    assign bus.moveL  = move_q[1];
    assign bus.moveR  = move_q[0];
    assign bus.debugA = dbg_q[3];
    assign bus.debugB = dbg_q[2];
    assign bus.debugC = dbg_q[1];
    assign bus.debugD = dbg_q[0];
    assign bus.mode   = state_q;
endmodule

// File: tb/tb_raybox_input_ctrl.sv
// Directed bench for raybox_input_ctrl with DEBOUNCE_CYCLES=4, CHORD_WINDOW=8, frame every 32 clk.
// Output vector order in checks: {moveF,moveB,moveL,moveR,debugA,debugB,debugC,debugD}.
module tb_raybox_input_ctrl;
    localparam int DB    = 4;
    localparam int CW    = 8;
    localparam int FRAME = 32;

    logic clk = 1'b0;
    logic reset;
    raybox_input_ctrl_if bus();

    raybox_input_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .CHORD_WINDOW    (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         n;
    int         pulses;
    logic       ticked;
    logic [7:0] mode_seen;
    logic [7:0] outs_or;

    function automatic logic [7:0] outs();
        return {bus.moveF, bus.moveB, bus.moveL, bus.moveR,
                bus.debugA, bus.debugB, bus.debugC, bus.debugD};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive frame_tick, take the edge, sample 1 time unit later.
    task automatic step();
        bus.frame_tick = (cyc % FRAME == FRAME - 1);
        @(posedge clk);
        #1;
        ticked = bus.frame_tick;
        cyc++;
        mode_seen = mode_seen | (8'd1 << bus.mode);
        outs_or   = outs_or | outs();
    endtask

    task automatic run(input int cnt);
        repeat (cnt) step();
    endtask

    task automatic wait_mode(input logic [2:0] m, input int limit, output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (bus.mode !== m && edges < limit);
    endtask

    task automatic wait_frame();
        do step(); while (!ticked);
    endtask

    initial begin
        reset          = 1'b1;
        bus.btn_n      = 4'hF;
        bus.frame_tick = 1'b0;
        mode_seen      = '0;
        outs_or        = '0;
        #2;
        chk("reset_mode", bus.mode, 0);
        chk("reset_outs", outs(), 0);
        run(3);
        reset = 1'b0;

        mode_seen = '0; outs_or = '0;
        run(200);
        chk("idle_modes", mode_seen, 8'h01);
        chk("idle_outs", outs_or, 0);

        // Bounce: 3 low, 2 high, 3 low never survives a 4-cycle debounce.
        mode_seen = '0; outs_or = '0;
        bus.btn_n = 4'b0111; run(3);
        bus.btn_n = 4'b1111; run(2);
        bus.btn_n = 4'b0111; run(3);
        bus.btn_n = 4'b1111; run(20);
        chk("bounce_modes", mode_seen, 8'h01);
        chk("bounce_outs", outs_or, 0);

        // Tap shorter than the chord window: PEND then back to IDLE, no MOVE.
        mode_seen = '0; outs_or = '0;
        bus.btn_n = 4'b0111; run(6);
        bus.btn_n = 4'b1111; run(20);
        chk("tap_modes", mode_seen, 8'h03);
        chk("tap_outs", outs_or, 0);

        // Forward move.
        bus.btn_n = 4'b0111;
        wait_mode(3'd1, 30, n);
        chk("move_pend_edge", n, 7);
        wait_mode(3'd2, 30, n);
        chk("move_edge", n, 8);
        chk("move_before_tick", outs(), 0);
        wait_frame();
        chk("moveF", outs(), 8'h80);
        bus.btn_n = 4'b1111;
        wait_mode(3'd0, 30, n);
        chk("move_release_edge", n, 7);
        wait_frame();
        chk("move_release_outs", outs(), 0);

        // Chord K3+K2 two cycles apart, then K4 for debugA, then drop K2.
        mode_seen = '0;
        bus.btn_n = 4'b1011; run(2);
        bus.btn_n = 4'b1001;
        wait_mode(3'd3, 30, n);
        chk("chord_mode", bus.mode, 3);
        chk("chord_no_move", mode_seen[2], 0);
        bus.btn_n = 4'b0001;
        run(DB + 3);
        wait_frame();
        chk("debugA", outs(), 8'h08);
        bus.btn_n = 4'b0011;
        wait_mode(3'd5, 30, n);
        chk("rel_edge", n, 7);
        wait_frame();
        chk("rel_outs", outs(), 0);
        chk("rel_hold", bus.mode, 5);
        bus.btn_n = 4'b1111;
        wait_mode(3'd0, 30, n);
        chk("rel_to_idle", bus.mode, 0);

        // Move left, then add right: cancel, chord ignored in MOVE.
        bus.btn_n = 4'b1011;
        wait_mode(3'd2, 40, n);
        chk("left_mode", bus.mode, 2);
        wait_frame();
        chk("moveL", outs(), 8'h20);
        mode_seen = '0;
        bus.btn_n = 4'b1001;
        run(DB + 3);
        wait_frame();
        chk("opposed_outs", outs(), 0);
        chk("opposed_modes", mode_seen, 8'h04);
        bus.btn_n = 4'b1111;
        wait_mode(3'd0, 30, n);
        chk("opposed_idle", bus.mode, 0);

        // All four from IDLE: C1 beats C2.
        mode_seen = '0;
        bus.btn_n = 4'b0000;
        wait_mode(3'd3, 30, n);
        chk("all_edge", n, 7);
        chk("all_modes", mode_seen, 8'h09);
        wait_frame();
        chk("all_debugAB", outs(), 8'h0C);
        bus.btn_n = 4'b1111;
        wait_mode(3'd0, 30, n);
        chk("all_idle", bus.mode, 0);
        wait_frame();
        chk("all_idle_outs", outs(), 0);

        // DBG2 via K4+K1, then K2 drives debugC.
        bus.btn_n = 4'b0110;
        wait_mode(3'd4, 30, n);
        chk("dbg2_edge", n, 7);
        wait_frame();
        chk("dbg2_quiet", outs(), 0);
        bus.btn_n = 4'b0100;
        run(DB + 3);
`ifdef RAYBOX_INPUT_DEBUG_PULSE_EN
        pulses = 0;
        repeat (5) begin
            wait_frame();
            if (bus.debugC) pulses++;
        end
        chk("pulse_first", pulses, 1);
        bus.btn_n = 4'b0110;
        run(DB + 3);
        wait_frame();
        wait_frame();
        bus.btn_n = 4'b0100;
        run(DB + 3);
        pulses = 0;
        repeat (5) begin
            wait_frame();
            if (bus.debugC) pulses++;
        end
        chk("pulse_second", pulses, 1);
`else
        pulses = 0;
        repeat (5) begin
            wait_frame();
            if (bus.debugC) pulses++;
        end
        chk("dbg2_level_frames", pulses, 5);
        chk("dbg2_level", outs(), 8'h02);
        bus.btn_n = 4'b0110;
        run(DB + 3);
        wait_frame();
        chk("dbg2_k2_off", outs(), 0);
        bus.btn_n = 4'b0100;
        run(DB + 3);
        wait_frame();
        chk("dbg2_k2_again", outs(), 8'h02);
`endif

        // Asynchronous reset between edges while in DBG2.
        chk("pre_reset_mode", bus.mode, 4);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_mode", bus.mode, 0);
        chk("async_reset_outs", outs(), 0);
        bus.btn_n = 4'b1111;
        step();
        reset = 1'b0;
        mode_seen = '0; outs_or = '0;
        run(40);
        chk("post_reset_modes", mode_seen, 8'h01);
        chk("post_reset_outs", outs_or, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
